// File: rtl/mult_alu.sv
// -----------------------------------------------------------------------------
// mult_alu : multiply unit of the Troy WideWord 128-bit SIMD ALU.
//
// Element-wise even/odd, signed/unsigned multiply of two 128-bit vectors.
// Each selected W-bit element pair yields an exact 2W-bit product. The
// products are packed left to right into a 128-bit result, which is
// registered with one cycle of latency.
//
// Bit 0 is the MSB on every vector port. Element k of width W occupies bits
// [kW : kW+W-1].
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous reset, active low
//   reg_A    in   [0:127] operand A
//   reg_B    in   [0:127] operand B
//   ctrl_ww  in   [0:1]  element width: 00=w8 01=w16 10=w32 11=w64
//   alu_op   in   [0:4]  01000 wmuleu, 01001 wmulou, 01010 wmules, 01011 wmulos
//   result   out  [0:127] registered product vector
// -----------------------------------------------------------------------------
module mult_alu (
   input  logic         clk,
   input  logic         rst,
   input  logic [0:127] reg_A,
   input  logic [0:127] reg_B,
   input  logic [0:1]   ctrl_ww,
   input  logic [0:4]   alu_op,
   output logic [0:127] result
);

   localparam logic [0:4] OP_WMULEU = 5'b01000;
   localparam logic [0:4] OP_WMULOU = 5'b01001;
   localparam logic [0:4] OP_WMULES = 5'b01010;
   localparam logic [0:4] OP_WMULOS = 5'b01011;

   localparam logic [0:1] WW_8  = 2'b00;
   localparam logic [0:1] WW_16 = 2'b01;
   localparam logic [0:1] WW_32 = 2'b10;

   logic         w_legal;
   logic         w_odd;
   logic         w_sgn;
   logic [0:127] w_prod;
   logic [0:127] r_result_p1;

   // A W x W product is exact in 2W bits for both signed and unsigned
   // operands, so extending to 2W and truncating the product is sufficient.
   function automatic logic [15:0] f_mul8(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic       sgn);
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      logic        [15:0] ua;
      logic        [15:0] ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {8'd0, a};
      ub = {8'd0, b};
      if (sgn) return sa * sb;
      else     return ua * ub;
   endfunction

   function automatic logic [31:0] f_mul16(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic        sgn);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic        [31:0] ua;
      logic        [31:0] ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {16'd0, a};
      ub = {16'd0, b};
      if (sgn) return sa * sb;
      else     return ua * ub;
   endfunction

   function automatic logic [63:0] f_mul32(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sgn);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic        [63:0] ua;
      logic        [63:0] ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (sgn) return sa * sb;
      else     return ua * ub;
   endfunction

   // Opcode decode: the low opcode bit picks odd elements, the next picks signed.
   always_comb begin
      w_legal = 1'b0;
      w_odd   = 1'b0;
      w_sgn   = 1'b0;
      case (alu_op)
         OP_WMULEU: begin w_legal = 1'b1;                                 end
         OP_WMULOU: begin w_legal = 1'b1; w_odd = 1'b1;                   end
         OP_WMULES: begin w_legal = 1'b1;                 w_sgn = 1'b1;   end
         OP_WMULOS: begin w_legal = 1'b1; w_odd = 1'b1;   w_sgn = 1'b1;   end
         default:   ;
      endcase
   end

   // Selected element of pair i is element 2i (even) or 2i+1 (odd); its
   // product goes to the i-th 2W-bit slot. w64 and illegal ops leave zero.
   always_comb begin
      w_prod = '0;
      if (w_legal) begin
         case (ctrl_ww)
            WW_8: begin
               for (int i = 0; i < 8; i++) begin
                  w_prod[i*16 +: 16] = f_mul8(reg_A[(2*i + (w_odd ? 1 : 0))*8 +: 8],
                                              reg_B[(2*i + (w_odd ? 1 : 0))*8 +: 8],
                                              w_sgn);
               end
            end
            WW_16: begin
               for (int i = 0; i < 4; i++) begin
                  w_prod[i*32 +: 32] = f_mul16(reg_A[(2*i + (w_odd ? 1 : 0))*16 +: 16],
                                               reg_B[(2*i + (w_odd ? 1 : 0))*16 +: 16],
                                               w_sgn);
               end
            end
            WW_32: begin
               for (int i = 0; i < 2; i++) begin
                  w_prod[i*64 +: 64] = f_mul32(reg_A[(2*i + (w_odd ? 1 : 0))*32 +: 32],
                                               reg_B[(2*i + (w_odd ? 1 : 0))*32 +: 32],
                                               w_sgn);
               end
            end
            default: ;
         endcase
      end
   end

   // ---- stage p1: registered result ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_result_p1 <= '0;
      else      r_result_p1 <= w_prod;
   end

   assign result = r_result_p1;

endmodule

// File: tb/tb_mult_alu.sv
// -----------------------------------------------------------------------------
// tb_mult_alu : scoreboard bench for mult_alu.
// Directed vectors plus random operations are issued on the falling edge and
// their expected result is queued; a monitor compares one queued entry per
// cycle just after each rising edge. Reset behaviour is checked directly.
// -----------------------------------------------------------------------------
module tb_mult_alu;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] a;
   logic [127:0] b;
   logic [1:0]   ww;
   logic [4:0]   op;
   logic [127:0] res;

   int checks = 0;
   int errors = 0;

   logic [127:0] exp_q[$];
   string        name_q[$];

   always #5 clk = ~clk;

   mult_alu dut (
      .clk     (clk),
      .rst     (rst),
      .reg_A   (a),
      .reg_B   (b),
      .ctrl_ww (ww),
      .alu_op  (op),
      .result  (res)
   );

   // Reference model: pull elements out arithmetically, multiply as integers.
   function automatic logic [127:0] model(input logic [127:0] ma,
                                          input logic [127:0] mb,
                                          input logic [1:0]   mww,
                                          input logic [4:0]   mop);
      logic [127:0] r, ea, eb, p, m, pm;
      longint       sa, sb, sp;
      int           w, n, e;
      r = '0;
      if (!(mop inside {5'b01000, 5'b01001, 5'b01010, 5'b01011}) || mww == 2'b11)
         return r;
      w = 8 << mww;
      n = 64 / w;
      m = (128'd1 << w) - 128'd1;
      for (int i = 0; i < n; i++) begin
         e  = 2*i + (mop[0] ? 1 : 0);
         ea = (ma >> (128 - (e+1)*w)) & m;
         eb = (mb >> (128 - (e+1)*w)) & m;
         if (mop[1]) begin
            sa = longint'(ea[63:0]);
            sb = longint'(eb[63:0]);
            if (ea[w-1]) sa = sa - (longint'(1) << w);
            if (eb[w-1]) sb = sb - (longint'(1) << w);
            sp = sa * sb;
            p  = {{64{sp[63]}}, sp};
         end else begin
            p = ea * eb;
         end
         pm = p & ((128'd1 << (2*w)) - 128'd1);
         r  = r | (pm << (128 - (i+1)*2*w));
      end
      return r;
   endfunction

   task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic issue(input string nm, input logic [127:0] ia, input logic [127:0] ib,
                        input logic [1:0] iww, input logic [4:0] iop);
      @(negedge clk);
      a  = ia;
      b  = ib;
      ww = iww;
      op = iop;
      exp_q.push_back(model(ia, ib, iww, iop));
      name_q.push_back(nm);
   endtask

   // Monitor: one result per cycle for every issued operation.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [127:0] e;
         string        nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         check(nm, res, e);
      end
   end

   initial begin
      rst = 1'b0;
      a   = '0;
      b   = '0;
      ww  = 2'b00;
      op  = 5'b00000;
      #12;
      check("reset_state", res, 128'h0);
      @(negedge clk);
      rst = 1'b1;

      issue("eu_w8",  128'h0402030405060708f00a0b0cff0eff00, 128'h03010202030303031004f505ff09fe10, 2'b00, 5'b01000);
      issue("eu_w16", 128'h000100020000ffff000f10bff103ffff, 128'h000200040006ffff000c100000120014, 2'b01, 5'b01000);
      issue("ou_w8",  128'h0102030405060708090aff0c0dff0fff, 128'h01010202030303031004040508000fff, 2'b00, 5'b01001);
      issue("ou_w16", 128'h0001000200000008000f10bff103ffff, 128'h0002000400060008000c001000120014, 2'b01, 5'b01001);
      issue("os_w8",  128'h0180010501f9015301040100013c0100, 128'h017f010901fa010001fd01f101b80100, 2'b00, 5'b01011);
      issue("os_w16", 128'h1111000211118000111120541111fff9, 128'hffff0004ffff7fffffff0000fffffffd, 2'b01, 5'b01011);
      issue("es_w8",  128'h80010501f9015301040100013c010001, 128'h7f010901fa010001fd01f101b8010001, 2'b00, 5'b01010);
      issue("es_w16", 128'h000211118000111120541111fff91111, 128'h0004ffff7fffffff0000fffffffdffff, 2'b01, 5'b01010);
      issue("eu_w32", 128'hffffffff1234567800000002deadbeef, 128'hffffffff8765432100000003cafef00d, 2'b10, 5'b01000);
      issue("w64",    128'hffffffff1234567800000002deadbeef, 128'hffffffff8765432100000003cafef00d, 2'b11, 5'b01000);
      issue("bad_op", 128'h0402030405060708f00a0b0cff0eff00, 128'h03010202030303031004f505ff09fe10, 2'b00, 5'b00000);

      for (int k = 0; k < 300; k++) begin
         logic [127:0] ra, rb;
         logic [4:0]   rop;
         int           sel;
         ra  = {$urandom, $urandom, $urandom, $urandom};
         rb  = {$urandom, $urandom, $urandom, $urandom};
         sel = $urandom_range(0, 9);
         if (sel < 8) rop = 5'b01000 + 5'(sel % 4);
         else         rop = 5'($urandom_range(0, 31));
         issue("random", ra, rb, 2'($urandom_range(0, 3)), rop);
      end

      // Reset while a non-zero result is held.
      issue("pre_reset", 128'h0402030405060708f00a0b0cff0eff00, 128'h03010202030303031004f505ff09fe10, 2'b00, 5'b01000);
      @(posedge clk);
      #3;
      check("pre_reset_nonzero", (res != 128'h0) ? 128'h1 : 128'h0, 128'h1);
      rst = 1'b0;
      #1;
      check("async_reset", res, 128'h0);
      @(posedge clk);
      #1;
      check("reset_held", res, 128'h0);
      @(negedge clk);
      rst = 1'b1;
      issue("post_reset", 128'h1111000211118000111120541111fff9, 128'hffff0004ffff7fffffff0000fffffffd, 2'b01, 5'b01011);

      // Bounded drain of the scoreboard.
      for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_alu.md
Name: mult_alu

Overview:
- Multiply unit of the Troy WideWord 128-bit SIMD ALU.
- Performs even/odd, signed/unsigned element-wise multiplication of two 128-bit vector registers.
- Each product is double-width and packed into a 128-bit result.
- The result is registered, with one cycle of latency, and feeds register-file writeback.

Parameters:
- None. Widths are fixed: 128-bit operands, 2-bit width select, 5-bit opcode.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- reg_A  input  [0:127]  operand A; bit 0 is the MSB, element 0 is the leftmost element.
- reg_B  input  [0:127]  operand B, same numbering as reg_A.
- ctrl_ww  input  [0:1]  element width: w8=2'b00, w16=2'b01, w32=2'b10, w64=2'b11.
- alu_op  input  [0:4]  operation: aluwmuleu=5'b01000, aluwmulou=5'b01001, aluwmules=5'b01010, aluwmulos=5'b01011.
- result  output  [0:127]  registered product vector.

Behaviour:
- Reset: while rst=0, result=0 immediately (asynchronous). Normal operation resumes on the first rising clk edge after rst returns to 1.
- Latency: inputs are sampled on the rising clk edge; result shows the product on that same edge. There is no handshake, and a new operation is accepted every cycle.
- Element numbering: elements of width W are numbered left to right from 0, so element k occupies bits [kW : kW+W-1].
- Even ops (wmuleu, wmules) use elements 0,2,4,…
- Odd ops (wmulou, wmulos) use elements 1,3,5,…
- Product placement: the product of the i-th selected pair, A[e]×B[e], is 2W bits wide. It goes into result bits [i·2W : i·2W+2W-1], so the first selected pair lands in the leftmost 2W bits.
- w8: 8 products of 8×8 bits, each 16 bits wide.
- w16: 4 products of 16×16 bits, each 32 bits wide.
- w32: 2 products of 32×32 bits, each 64 bits wide.
- Unsigned ops (…eu, …ou): operands are zero-extended and the product is exact.
- Signed ops (…es, …os): operands are two's complement and the product is an exact two's-complement value. Example: 0x80×0x7F gives 0xC080.
- No saturation and no overflow is possible, because 2W bits always holds the full product.
- ctrl_ww=w64: result=0 for every op.
- Any alu_op value other than the four above: result=0.
- Unselected elements (odd elements for even ops, even elements for odd ops) have no influence on result.

Test Plan:
- wmuleu, w8: A=0402030405060708f00a0b0cff0eff00, B=03010202030303031004f505ff09fe10 -> result 000c0006000f00150f000a87fe01fd02 one cycle later.
- wmuleu, w16: A=000100020000ffff000f10bff103ffff, B=000200040006ffff000c100000120014 -> 0000000200000000000000b40010f236.
- wmulou: w8, A=0102030405060708090aff0c0dff0fff, B=01010202030303031004040508000fff -> 00020008001200180028003c0000fe01. w16, A=0001000200000008000f10bff103ffff, B=0002000400060008000c001000120014 -> 000000080000004000010bf00013ffec.
- wmulos / wmules:
  - wmulos w8, A=0180010501f9015301040100013c0100, B=017f010901fa010001fd01f101b80100 -> c080002d002a0000fff40000ef200000.
  - wmulos w16, A=1111000211118000111120541111fff9, B=ffff0004ffff7fffffff0000fffffffd -> 00000008c00080000000000000000015.
  - wmules with the same operands shifted one element left gives identical results: w8 A=80010501f9015301040100013c010001, B=7f010901fa010001fd01f101b8010001; w16 A=000211118000111120541111fff91111, B=0004ffff7fffffff0000fffffffdffff.
- w32 and illegal cases:
  - wmuleu w32, A=ffffffff_x_00000002_x, B=ffffffff_x_00000003_x -> fffffffe00000001_0000000000000006.
  - ctrl_ww=w64 -> result 0.
  - alu_op=5'b00000 -> result 0.
- Reset: assert rst=0 mid-stream with a non-zero result -> result goes to 0 without waiting for clk. Release rst -> the next clk edge loads a correct product.
